// File: rtl/msrv32_pkg.sv
// Shared encodings for the machine-mode trap controller: FSM states,
// PC source select codes, mcause codes and SYSTEM instruction decode constants.
package msrv32_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } trap_state_t;

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_NEXT = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_EPC  = 2'b11;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] CAUSE_M_SW_IRQ         = 4'd3;
    localparam logic [3:0] CAUSE_M_TMR_IRQ        = 4'd7;
    localparam logic [3:0] CAUSE_M_EXT_IRQ        = 4'd11;

    localparam logic [4:0]  OPCODE_SYSTEM  = 5'b11100;
    localparam logic [11:0] FUNCT12_ECALL  = 12'h000;
    localparam logic [11:0] FUNCT12_EBREAK = 12'h001;
    localparam logic [11:0] FUNCT12_MRET   = 12'h302;

    localparam int HOLD_W = 4;

endpackage

// File: rtl/msrv32_trap_prio.sv
// Combinational trap priority encoder: interrupts beat exceptions, and the
// first asserted source in the fixed order below supplies the mcause code.
module msrv32_trap_prio
    import msrv32_pkg::*;
(
    input  logic       i_ext_irq,
    input  logic       i_sw_irq,
    input  logic       i_tmr_irq,
    input  logic       i_instr_misaligned,
    input  logic       i_illegal,
    input  logic       i_ecall,
    input  logic       i_ebreak,
    input  logic       i_load_misaligned,
    input  logic       i_store_misaligned,
    output logic       o_valid,
    output logic       o_int_or_exc,
    output logic [3:0] o_cause
);

    always_comb begin
        o_valid      = 1'b1;
        o_int_or_exc = 1'b0;
        o_cause      = 4'd0;
        if (i_ext_irq) begin
            o_int_or_exc = 1'b1;
            o_cause      = CAUSE_M_EXT_IRQ;
        end else if (i_sw_irq) begin
            o_int_or_exc = 1'b1;
            o_cause      = CAUSE_M_SW_IRQ;
        end else if (i_tmr_irq) begin
            o_int_or_exc = 1'b1;
            o_cause      = CAUSE_M_TMR_IRQ;
        end else if (i_instr_misaligned) begin
            o_cause = CAUSE_INSTR_MISALIGNED;
        end else if (i_illegal) begin
            o_cause = CAUSE_ILLEGAL_INSTR;
        end else if (i_ecall) begin
            o_cause = CAUSE_ECALL_M;
        end else if (i_ebreak) begin
            o_cause = CAUSE_BREAKPOINT;
        end else if (i_load_misaligned) begin
            o_cause = CAUSE_LOAD_MISALIGNED;
        end else if (i_store_misaligned) begin
            o_cause = CAUSE_STORE_MISALIGNED;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap sequencer: decides trap entry / MRET return and drives
// PC select, flush and the mepc/mcause/mstatus write strobes.
module msrv32_trap_controller
    import msrv32_pkg::*;
#(
    parameter int RESET_HOLD = 1
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs2_addr_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       e_irq_in,
    input  logic       t_irq_in,
    input  logic       s_irq_in,
    output logic       trap_taken_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic [3:0] cause_out,
    output logic       int_or_exc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       instret_inc_out
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    trap_state_t       r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [3:0]        r_cause;
    logic              r_int_or_exc;

    logic [11:0] w_funct12;
    logic        w_is_system;
    logic        w_ecall;
    logic        w_ebreak;
    logic        w_mret;
    logic        w_trap_valid;
    logic        w_trap_int;
    logic [3:0]  w_trap_cause;

    assign w_funct12   = {funct7_in, rs2_addr_in};
    assign w_is_system = (opcode_6_to_2_in == OPCODE_SYSTEM) && (funct3_in == 3'd0);
    assign w_ecall     = w_is_system && (w_funct12 == FUNCT12_ECALL);
    assign w_ebreak    = w_is_system && (w_funct12 == FUNCT12_EBREAK);
    assign w_mret      = w_is_system && (w_funct12 == FUNCT12_MRET);

    msrv32_trap_prio u_prio (
        .i_ext_irq          (mie_in & meie_in & e_irq_in),
        .i_sw_irq           (mie_in & msie_in & s_irq_in),
        .i_tmr_irq          (mie_in & mtie_in & t_irq_in),
        .i_instr_misaligned (misaligned_instr_in),
        .i_illegal          (illegal_instr_in),
        .i_ecall            (w_ecall),
        .i_ebreak           (w_ebreak),
        .i_load_misaligned  (misaligned_load_in),
        .i_store_misaligned (misaligned_store_in),
        .o_valid            (w_trap_valid),
        .o_int_or_exc       (w_trap_int),
        .o_cause            (w_trap_cause)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_RESET;
            r_hold       <= '0;
            r_cause      <= 4'd0;
            r_int_or_exc <= 1'b0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state <= ST_OPERATING;
                        r_hold  <= '0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_OPERATING: begin
                    if (w_trap_valid) begin
                        r_state      <= ST_TRAP_TAKEN;
                        r_cause      <= w_trap_cause;
                        r_int_or_exc <= w_trap_int;
                    end else if (w_mret) begin
                        r_state <= ST_TRAP_RETURN;
                    end
                end
                ST_TRAP_TAKEN, ST_TRAP_RETURN: r_state <= ST_OPERATING;
                default: r_state <= ST_RESET;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset drops every strobe at once.
    always_comb begin
        trap_taken_out  = 1'b0;
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        pc_src_out      = PC_SRC_BOOT;
        flush_out       = 1'b0;
        instret_inc_out = 1'b0;
        case (r_state)
            ST_RESET: begin
                flush_out = 1'b1;
            end
            ST_OPERATING: begin
                pc_src_out      = PC_SRC_NEXT;
                trap_taken_out  = w_trap_valid | w_mret;
                instret_inc_out = ~(w_trap_valid | w_mret);
            end
            ST_TRAP_TAKEN: begin
                set_epc_out   = 1'b1;
                set_cause_out = 1'b1;
                mie_clear_out = 1'b1;
                pc_src_out    = PC_SRC_TRAP;
                flush_out     = 1'b1;
            end
            ST_TRAP_RETURN: begin
                mie_set_out     = 1'b1;
                pc_src_out      = PC_SRC_EPC;
                flush_out       = 1'b1;
                instret_inc_out = 1'b1;
            end
            default: flush_out = 1'b1;
        endcase
    end

    assign cause_out      = r_cause;
    assign int_or_exc_out = r_int_or_exc;

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// Scoreboard bench for msrv32_trap_controller: a cycle-level reference model
// pushes expected outputs, a negedge monitor pops and compares them.
module tb_msrv32_trap_controller;

    localparam int RESET_HOLD = 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic        tt;
        logic        epc;
        logic        scause;
        logic        clr;
        logic        set;
        logic        flush;
        logic        instret;
        logic [1:0]  pc;
        logic [3:0]  cause;
        logic        intr;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic [4:0] opcode_6_to_2_in = 5'd0;
    logic [2:0] funct3_in = 3'd0;
    logic [6:0] funct7_in = 7'd0;
    logic [4:0] rs2_addr_in = 5'd0;
    logic       illegal_instr_in = 1'b0, misaligned_load_in = 1'b0;
    logic       misaligned_store_in = 1'b0, misaligned_instr_in = 1'b0;
    logic       mie_in = 1'b0, meie_in = 1'b0, mtie_in = 1'b0, msie_in = 1'b0;
    logic       e_irq_in = 1'b0, t_irq_in = 1'b0, s_irq_in = 1'b0;
    logic       trap_taken_out, set_epc_out, set_cause_out, int_or_exc_out;
    logic       mie_clear_out, mie_set_out, flush_out, instret_inc_out;
    logic [3:0] cause_out;
    logic [1:0] pc_src_out;

    // staged stimulus, applied just after the next rising edge
    logic       s_rst_n;
    logic [4:0] s_op;
    logic [2:0] s_f3;
    logic [6:0] s_f7;
    logic [4:0] s_rs2;
    logic       s_ill, s_ld, s_st, s_mi;
    logic       s_mie, s_meie, s_mtie, s_msie, s_eirq, s_tirq, s_sirq;

    // reference model state
    int         m_boot = 0;
    int         m_last = 0;   // 0 none, 1 trap entered, 2 mret accepted
    logic [3:0] m_cause = 4'd0;
    logic       m_int = 1'b0;
    int         cyc = 0;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk_in = ~clk_in;

    msrv32_trap_controller #(.RESET_HOLD(RESET_HOLD)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in),
        .funct7_in(funct7_in), .rs2_addr_in(rs2_addr_in),
        .illegal_instr_in(illegal_instr_in), .misaligned_load_in(misaligned_load_in),
        .misaligned_store_in(misaligned_store_in), .misaligned_instr_in(misaligned_instr_in),
        .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
        .e_irq_in(e_irq_in), .t_irq_in(t_irq_in), .s_irq_in(s_irq_in),
        .trap_taken_out(trap_taken_out), .set_epc_out(set_epc_out),
        .set_cause_out(set_cause_out), .cause_out(cause_out),
        .int_or_exc_out(int_or_exc_out), .mie_clear_out(mie_clear_out),
        .mie_set_out(mie_set_out), .pc_src_out(pc_src_out),
        .flush_out(flush_out), .instret_inc_out(instret_inc_out)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input logic [31:0] c);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    task automatic idle();
        s_rst_n = 1'b1;
        s_op = 5'b01100; s_f3 = 3'd0; s_f7 = 7'd0; s_rs2 = 5'd0;
        {s_ill, s_ld, s_st, s_mi} = 4'b0;
        {s_mie, s_meie, s_mtie, s_msie, s_eirq, s_tirq, s_sirq} = 7'b0;
    endtask

    task automatic set_sys(input logic [11:0] f12);
        s_op = 5'b11100; s_f3 = 3'd0;
        s_f7 = f12[11:5]; s_rs2 = f12[4:0];
    endtask

    task automatic step();
        exp_t       e;
        logic [11:0] f12;
        logic       sys;
        logic       hit [9];
        logic [3:0] codes [9];
        int         found;
        @(posedge clk_in);
        #1;
        rst_n_in = s_rst_n;
        opcode_6_to_2_in = s_op; funct3_in = s_f3; funct7_in = s_f7; rs2_addr_in = s_rs2;
        illegal_instr_in = s_ill; misaligned_load_in = s_ld;
        misaligned_store_in = s_st; misaligned_instr_in = s_mi;
        mie_in = s_mie; meie_in = s_meie; mtie_in = s_mtie; msie_in = s_msie;
        e_irq_in = s_eirq; t_irq_in = s_tirq; s_irq_in = s_sirq;
        cyc++;
        e = '0;
        e.cyc = cyc;
        e.cause = m_cause;
        e.intr = m_int;
        if (!s_rst_n) begin
            e.flush = 1'b1;
            e.cause = 4'd0; e.intr = 1'b0;
            m_cause = 4'd0; m_int = 1'b0;
            m_boot = RESET_HOLD; m_last = 0;
        end else if (m_boot > 0) begin
            e.flush = 1'b1;
            m_boot--;
        end else if (m_last == 1) begin
            e.epc = 1'b1; e.scause = 1'b1; e.clr = 1'b1;
            e.pc = 2'b10; e.flush = 1'b1;
            m_last = 0;
        end else if (m_last == 2) begin
            e.set = 1'b1; e.pc = 2'b11; e.flush = 1'b1; e.instret = 1'b1;
            m_last = 0;
        end else begin
            e.pc = 2'b01;
            f12 = {s_f7, s_rs2};
            sys = (s_op == 5'b11100) && (s_f3 == 3'd0);
            hit = '{s_mie & s_meie & s_eirq, s_mie & s_msie & s_sirq, s_mie & s_mtie & s_tirq,
                    s_mi, s_ill, sys && f12 == 12'h000, sys && f12 == 12'h001, s_ld, s_st};
            codes = '{4'd11, 4'd3, 4'd7, 4'd0, 4'd2, 4'd11, 4'd3, 4'd4, 4'd6};
            found = -1;
            for (int i = 0; i < 9; i++)
                if (hit[i] && found < 0) found = i;
            if (found >= 0) begin
                e.tt = 1'b1;
                m_cause = codes[found];
                m_int = (found < 3);
                m_last = 1;
            end else if (sys && f12 == 12'h302) begin
                e.tt = 1'b1;
                m_last = 2;
            end else begin
                e.instret = 1'b1;
            end
        end
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("trap_taken", 32'(trap_taken_out), 32'(e.tt), e.cyc);
                chk("set_epc", 32'(set_epc_out), 32'(e.epc), e.cyc);
                chk("set_cause", 32'(set_cause_out), 32'(e.scause), e.cyc);
                chk("mie_clear", 32'(mie_clear_out), 32'(e.clr), e.cyc);
                chk("mie_set", 32'(mie_set_out), 32'(e.set), e.cyc);
                chk("flush", 32'(flush_out), 32'(e.flush), e.cyc);
                chk("instret", 32'(instret_inc_out), 32'(e.instret), e.cyc);
                chk("pc_src", 32'(pc_src_out), 32'(e.pc), e.cyc);
                chk("cause", 32'(cause_out), 32'(e.cause), e.cyc);
                chk("int_or_exc", 32'(int_or_exc_out), 32'(e.intr), e.cyc);
            end
        end
    end

    initial begin : stimulus
        idle();
        s_rst_n = 1'b0;
        step(); step();
        s_rst_n = 1'b1;
        step(); step(); step();

        idle(); s_ill = 1'b1; step();
        idle(); step(); step();

        idle(); set_sys(12'h000); step();
        idle(); step(); step();

        idle(); set_sys(12'h001); step();
        idle(); step(); step();

        idle(); set_sys(12'h302); step();
        idle(); step(); step();

        idle(); s_tirq = 1'b1; s_mtie = 1'b1; s_mie = 1'b1; s_ld = 1'b1; step();
        idle(); step(); step();
        idle(); s_tirq = 1'b1; s_mtie = 1'b1; s_mie = 1'b0; s_ld = 1'b1; step();
        idle(); step(); step();

        idle(); s_mie = 1'b1; s_meie = 1'b1; s_eirq = 1'b1; set_sys(12'h302); step();
        idle(); step(); step();

        idle(); s_mie = 1'b1; s_msie = 1'b1; s_sirq = 1'b1; s_mi = 1'b1; s_st = 1'b1; step();
        idle(); s_st = 1'b1; step(); step(); step();

        idle(); s_ill = 1'b1; step(); step(); step();

        idle(); s_ill = 1'b1; step();
        idle(); s_rst_n = 1'b0; step();
        s_rst_n = 1'b1; step(); step(); step();

        for (int n = 0; n < 2000; n++) begin
            int k;
            idle();
            k = int'($urandom_range(0, 9));
            case (k)
                0: set_sys(12'h000);
                1: set_sys(12'h001);
                2, 3: set_sys(12'h302);
                4: begin set_sys(12'h000); s_f3 = 3'($urandom_range(1, 7)); end
                5: begin set_sys(12'h302); s_op = 5'($urandom_range(0, 27)); end
                default: begin
                    s_op = 5'($urandom); s_f3 = 3'($urandom);
                    s_f7 = 7'($urandom); s_rs2 = 5'($urandom);
                end
            endcase
            s_ill = ($urandom_range(0, 11) == 0);
            s_ld  = ($urandom_range(0, 11) == 0);
            s_st  = ($urandom_range(0, 11) == 0);
            s_mi  = ($urandom_range(0, 11) == 0);
            s_mie = 1'($urandom); s_meie = 1'($urandom);
            s_mtie = 1'($urandom); s_msie = 1'($urandom);
            s_eirq = ($urandom_range(0, 5) == 0);
            s_tirq = ($urandom_range(0, 5) == 0);
            s_sirq = ($urandom_range(0, 5) == 0);
            s_rst_n = ($urandom_range(0, 149) != 0);
            step();
        end

        idle(); step(); step();
        @(negedge clk_in);
        #1;
        chk("scoreboard_drain", 32'(sb_q.size()), 32'd0, 32'(cyc));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
